// File: rtl/vgc_timing.sv
// Video timing generator for the VGC raster engine: pixel clock-enable, H/V raster
// counters, registered sync/blank decode, frame/VBL pulses and IIGS count snapshot.
module vgc_timing #(
    parameter int         CE_DIV    = 2,
    parameter int         H_TOTAL   = 924,
    parameter int         H_VISIBLE = 704,
    parameter int         HS_START  = 760,
    parameter int         HS_END    = 824,
    parameter int         V_TOTAL   = 262,
    parameter int         V_VISIBLE = 224,
    parameter int         VS_START  = 234,
    parameter int         VS_END    = 237,
    parameter logic [8:0] VCNT_BASE = 9'h0FA
) (
    input  logic       clk_vid,
    input  logic       reset_n,
    output logic       ce_pix,
    output logic [9:0] H,
    output logic [8:0] V,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       sof,
    output logic       vbl_start,
    input  logic       cnt_rd,
    output logic [7:0] vertcnt,
    output logic [7:0] horizcnt
);

    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_S     = 10'(HS_START);
    localparam logic [9:0] HS_E     = 10'(HS_END);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS    = 9'(V_VISIBLE);
    localparam logic [8:0] VS_S     = 9'(VS_START);
    localparam logic [8:0] VS_E     = 9'(VS_END);

    logic [3:0] div_reg;
    logic [3:0] div_next;
    logic       ce_next;
    logic [9:0] h_next;
    logic [8:0] v_next;
    logic [3:0] hsub_reg;
    logic [3:0] hsub_next;
    logic [6:0] hslot_reg;
    logic [6:0] hslot_next;
    logic [7:0] hslot_sum;
    logic [6:0] hcount;
    logic [8:0] vcount;

    always_comb begin
        ce_next    = (div_reg == DIV_LAST);
        div_next   = ce_next ? 4'd0 : div_reg + 4'd1;
        h_next     = H;
        v_next     = V;
        hsub_next  = hsub_reg;
        hslot_next = hslot_reg;
        if (ce_pix) begin
            if (H == H_LAST) begin
                h_next     = 10'd0;
                hsub_next  = 4'd0;
                hslot_next = 7'd0;
                v_next     = (V == V_LAST) ? 9'd0 : V + 9'd1;
            end else begin
                h_next = H + 10'd1;
                if (hsub_reg == 4'd13) begin
                    hsub_next  = 4'd0;
                    hslot_next = hslot_reg + 7'd1;
                end else begin
                    hsub_next = hsub_reg + 4'd1;
                end
            end
        end
    end

    // hcount = 0x40 + hslot - 1 for hslot >= 1; bit 7 of the sum flags overflow past 0x7F
    assign hslot_sum = 8'h3F + {1'b0, hslot_reg};
    assign hcount    = (hslot_reg == 7'd0) ? 7'd0 :
                       (hslot_sum[7] ? 7'h7F : hslot_sum[6:0]);
    assign vcount    = VCNT_BASE + V;

    // Decodes are computed from the next H/V so they line up with the registered counters.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            div_reg   <= 4'd0;
            ce_pix    <= 1'b0;
            H         <= 10'd0;
            V         <= 9'd0;
            hsub_reg  <= 4'd0;
            hslot_reg <= 7'd0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            hblank    <= 1'b0;
            vblank    <= 1'b0;
            sof       <= 1'b0;
            vbl_start <= 1'b0;
            vertcnt   <= 8'd0;
            horizcnt  <= 8'd0;
        end else begin
            div_reg   <= div_next;
            ce_pix    <= ce_next;
            H         <= h_next;
            V         <= v_next;
            hsub_reg  <= hsub_next;
            hslot_reg <= hslot_next;
            hsync     <= (h_next >= HS_S) && (h_next < HS_E);
            vsync     <= (v_next >= VS_S) && (v_next < VS_E);
            hblank    <= (h_next >= H_VIS);
            vblank    <= (v_next >= V_VIS);
            sof       <= ce_next && (h_next == 10'd0) && (v_next == 9'd0);
            vbl_start <= ce_next && (h_next == 10'd0) && (v_next == V_VIS);
            if (cnt_rd) begin
                vertcnt  <= vcount[8:1];
                horizcnt <= {vcount[0], hcount};
            end
        end
    end

endmodule

// File: tb/tb_vgc_timing.sv
// Scoreboard bench for vgc_timing: raster events and snapshots are queued as expectations
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_vgc_timing;

    localparam int H_TOT  = 924;
    localparam int H_VIS  = 704;
    localparam int HS_S   = 760;
    localparam int HS_E   = 824;
    localparam int V_TOT  = 12;
    localparam int V_VIS  = 8;
    localparam int VS_S   = 9;
    localparam int VS_E   = 11;
    localparam int BUDGET = 30000;

    typedef enum int {
        EV_HWRAP, EV_VB_RISE, EV_VB_FALL, EV_VS_RISE, EV_VS_FALL,
        EV_SOF, EV_VBL, EV_HB_RISE, EV_HS_RISE, EV_HS_FALL
    } ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       h;
        int       v;
        int       ce;
    } ev_t;

    typedef struct {
        logic [7:0] vc;
        logic [7:0] hc;
    } snap_t;

    logic       clk_vid = 1'b0;
    logic       reset_n = 1'b0;
    logic       cnt_rd  = 1'b0;
    logic       ce_pix;
    logic [9:0] H;
    logic [8:0] V;
    logic       hsync, vsync, hblank, vblank, sof, vbl_start;
    logic [7:0] vertcnt, horizcnt;

    int    checks   = 0;
    int    failures = 0;
    ev_t   ev_q[$];
    snap_t snap_q[$];

    logic       snap_seen = 1'b0;
    logic [9:0] h_prev    = 10'd0;
    logic       hb_prev   = 1'b0;
    logic       hs_prev   = 1'b0;
    logic       vb_prev   = 1'b0;
    logic       vs_prev   = 1'b0;

    vgc_timing #(
        .CE_DIV(2), .H_TOTAL(H_TOT), .H_VISIBLE(H_VIS), .HS_START(HS_S), .HS_END(HS_E),
        .V_TOTAL(V_TOT), .V_VISIBLE(V_VIS), .VS_START(VS_S), .VS_END(VS_E),
        .VCNT_BASE(9'h1F4)
    ) dut (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .H(H), .V(V),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .sof(sof), .vbl_start(vbl_start), .cnt_rd(cnt_rd),
        .vertcnt(vertcnt), .horizcnt(horizcnt)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int h, input int v);
        ev_t e;
        e.kind = k;
        e.h    = h;
        e.v    = v;
        e.ce   = (k == EV_SOF || k == EV_VBL) ? 1 : 0;
        ev_q.push_back(e);
    endtask

    task automatic push_line(input int v);
        if (v == 0)     push_ev(EV_SOF, 0, 0);
        if (v == V_VIS) push_ev(EV_VBL, 0, v);
        push_ev(EV_HB_RISE, H_VIS, v);
        push_ev(EV_HS_RISE, HS_S, v);
        push_ev(EV_HS_FALL, HS_E, v);
    endtask

    task automatic push_wrap(input int v);
        int nv;
        nv = (v + 1) % V_TOT;
        push_ev(EV_HWRAP, 0, nv);
        if (nv == V_VIS) push_ev(EV_VB_RISE, 0, nv);
        if (nv == 0)     push_ev(EV_VB_FALL, 0, nv);
        if (nv == VS_S)  push_ev(EV_VS_RISE, 0, nv);
        if (nv == VS_E)  push_ev(EV_VS_FALL, 0, nv);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL event: got unexpected %s at H=%0d V=%0d", k.name(), H, V);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != k || e.h != int'(H) || e.v != int'(V) || e.ce != int'(ce_pix)) begin
                failures++;
                $display("FAIL event: got %s H=%0d V=%0d ce=%0d, expected %s H=%0d V=%0d ce=%0d",
                         k.name(), H, V, ce_pix, e.kind.name(), e.h, e.v, e.ce);
            end else begin
                $display("ok   event %s H=%0d V=%0d", k.name(), H, V);
            end
        end
    endtask

    task automatic check_snap();
        snap_t s;
        checks++;
        if (snap_q.size() == 0) begin
            failures++;
            $display("FAIL snapshot: got unexpected capture %h/%h", vertcnt, horizcnt);
        end else begin
            s = snap_q.pop_front();
            if (vertcnt !== s.vc || horizcnt !== s.hc) begin
                failures++;
                $display("FAIL snapshot: got vertcnt=%h horizcnt=%h, expected vertcnt=%h horizcnt=%h",
                         vertcnt, horizcnt, s.vc, s.hc);
            end else begin
                $display("ok   snapshot vertcnt=%h horizcnt=%h", vertcnt, horizcnt);
            end
        end
    endtask

    always @(posedge clk_vid) snap_seen <= cnt_rd;

    always @(negedge clk_vid) begin
        if (reset_n) begin
            if (snap_seen)              check_snap();
            if (H == 10'd0 && h_prev != 10'd0) observe(EV_HWRAP);
            if (vblank && !vb_prev)     observe(EV_VB_RISE);
            if (!vblank && vb_prev)     observe(EV_VB_FALL);
            if (vsync && !vs_prev)      observe(EV_VS_RISE);
            if (!vsync && vs_prev)      observe(EV_VS_FALL);
            if (sof)                    observe(EV_SOF);
            if (vbl_start)              observe(EV_VBL);
            if (hblank && !hb_prev)     observe(EV_HB_RISE);
            if (hsync && !hs_prev)      observe(EV_HS_RISE);
            if (!hsync && hs_prev)      observe(EV_HS_FALL);
        end
        h_prev  <= H;
        hb_prev <= hblank;
        hs_prev <= hsync;
        vb_prev <= vblank;
        vs_prev <= vsync;
    end

    // Returns at posedge+1 of the cycle where ce_pix is high in slot (h, v).
    task automatic wait_at(input int h, input int v);
        for (int n = 0; n < BUDGET; n++) begin
            @(posedge clk_vid);
            #1;
            if (ce_pix && int'(H) == h && int'(V) == v) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_at: slot H=%0d V=%0d not reached within %0d cycles", h, v, BUDGET);
    endtask

    task automatic snap_at(input int h, input int v, input logic [7:0] vc, input logic [7:0] hc);
        snap_t s;
        wait_at(h, v);
        s.vc = vc;
        s.hc = hc;
        snap_q.push_back(s);
        cnt_rd = 1'b1;
        @(posedge clk_vid);
        #1;
        cnt_rd = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_vid);
        #1;
        check("reset_hv",    {22'd0, H, V}, 32'd0);
        check("reset_flags", {25'd0, ce_pix, hsync, vsync, hblank, vblank, sof, vbl_start}, 32'd0);
        check("reset_snap",  {16'd0, vertcnt, horizcnt}, 32'd0);

        // Expected raster events: full frame 0, then frame 1 up to line 9 hsync start.
        for (int v = 0; v < V_TOT; v++) begin
            push_line(v);
            push_wrap(v);
        end
        for (int v = 0; v < 9; v++) begin
            push_line(v);
            push_wrap(v);
        end
        push_ev(EV_HB_RISE, H_VIS, 9);
        push_ev(EV_HS_RISE, HS_S, 9);

        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_vid);
            #1;
            check($sformatf("ce_seq_%0d", i), {31'd0, ce_pix}, i % 2);
            if (i == 1) begin
                snap_t s;
                s.vc = 8'hFA;
                s.hc = 8'h00;
                snap_q.push_back(s);
                cnt_rd = 1'b1;
            end
            if (i == 2) begin
                cnt_rd = 1'b0;
                check("h_after_first_ce", {22'd0, H}, 32'd1);
            end
        end

        snap_at(923, 1, 8'hFA, 8'hFF);
        snap_at(895, 2, 8'hFB, 8'h7E);
        snap_at(14, 11, 8'hFF, 8'hC0);
        snap_at(28, 0, 8'hFA, 8'h41);

        wait_at(780, 9);
        check("snap_hold", {16'd0, vertcnt, horizcnt}, {16'd0, 8'hFA, 8'h41});
        check("events_before_reset", ev_q.size(), 32'd0);

        #2 reset_n = 1'b0;
        #1;
        check("midreset_hv",    {22'd0, H, V}, 32'd0);
        check("midreset_flags", {25'd0, ce_pix, hsync, vsync, hblank, vblank, sof, vbl_start}, 32'd0);
        check("midreset_snap",  {16'd0, vertcnt, horizcnt}, 32'd0);
        repeat (3) @(posedge clk_vid);
        #1;
        push_line(0);
        push_wrap(0);
        reset_n = 1'b1;

        wait_at(10, 1);
        repeat (4) @(posedge clk_vid);
        #1;
        check("events_drained", ev_q.size(), 32'd0);
        check("snaps_drained", snap_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vgc_timing.md
Name: vgc_timing

Overview:
- Video timing generator sitting directly upstream of the VGC raster engine.
- Derives the pixel clock-enable from clk_vid and runs the H/V raster counters that the VGC consumes for border, palette/SCB fetch and pixel-slot decisions.
- Produces sync/blank for the scaler/output path.
- Provides an IIGS-style vertical/horizontal count snapshot (for $C02E/$C02F reads) and frame/VBL-start pulses.

Parameters:
- CE_DIV, 2: clk_vid cycles per ce_pix; range 1..15.
- H_TOTAL, 924: pixel slots per line (H = 0..H_TOTAL-1). Must be a multiple of 14 and ≥ 913 so the VGC's H=0x38C..0x390 fetch window exists.
- H_VISIBLE, 704: border + active width; hblank when H ≥ H_VISIBLE.
- HS_START, 760: first H with hsync asserted.
- HS_END, 824: first H with hsync deasserted.
- V_TOTAL, 262: lines per frame (V = 0..V_TOTAL-1).
- V_VISIBLE, 224: border + active lines; vblank when V ≥ V_VISIBLE.
- VS_START, 234: first V with vsync asserted.
- VS_END, 237: first V with vsync deasserted.
- VCNT_BASE, 9'h0FA: vertical count value reported at V=0.

Ports:
- clk_vid, input, 1: video clock.
- reset_n, input, 1: asynchronous active-low reset.
- ce_pix, output, 1: pixel enable, high one clk_vid cycle in every CE_DIV.
- H, output, 10: horizontal pixel counter.
- V, output, 9: vertical line counter.
- hsync, output, 1: active-high horizontal sync.
- vsync, output, 1: active-high vertical sync.
- hblank, output, 1: horizontal blank.
- vblank, output, 1: vertical blank.
- sof, output, 1: start of frame; one ce_pix-qualified cycle when H=0,V=0.
- vbl_start, output, 1: one ce_pix-qualified cycle when H=0,V=V_VISIBLE.
- cnt_rd, input, 1: single-cycle snapshot request from the bus side.
- vertcnt, output, 8: latched vertical count [8:1] ($C02E).
- horizcnt, output, 8: latched {vcount[0], hcount[6:0]} ($C02F).

Behaviour:
- Reset (reset_n low, asynchronous): every output and internal counter is 0. ce_pix low, H=0, V=0, all syncs/blanks 0, sof=0, vbl_start=0, vertcnt=0, horizcnt=0.
- Release: the first ce_pix pulse occurs CE_DIV cycles after the first clk_vid edge with reset_n high.
- Divider: counter 0..CE_DIV-1. ce_pix is registered and high on the cycle the divider wraps. With CE_DIV=1, ce_pix is constant 1 after reset.
- Raster counters: H increments on cycles where ce_pix is high.
  - At H=H_TOTAL-1, H wraps to 0 and V increments.
  - At V=V_TOTAL-1 with H wrap, V wraps to 0.
  - H/V hold when ce_pix is low.
- Decode outputs (hsync, vsync, hblank, vblank, sof, vbl_start) are registered and aligned with H/V. They reflect the current H/V value, so there is no extra pixel of lag.
  - hsync = HS_START ≤ H < HS_END.
  - vsync = VS_START ≤ V < VS_END.
  - hblank = H ≥ H_VISIBLE.
  - vblank = V ≥ V_VISIBLE.
  - sof and vbl_start are high only during the single clk_vid cycle that ce_pix is high in the qualifying slot.
- Horizontal count: a sub-counter hsub (0..13) advances on ce_pix and resets with H=0. A slot counter hslot increments when hsub wraps.
  - hcount = 0 when hslot=0.
  - Otherwise hcount = 7'h40 + hslot - 1, saturating at 7'h7F.
- Vertical count: vcount = VCNT_BASE + V, 9-bit modulo arithmetic. With the defaults, V=261 gives 9'h1FF, then V=0 gives 9'h0FA.
- Snapshot: when cnt_rd is high on a clk_vid edge, vertcnt and horizcnt load coherently from the live vcount/hcount in that cycle.
  - If cnt_rd coincides with a counter advance, the pre-advance values are captured.
  - Outputs hold between snapshots.
- Reset mid-frame: all counters return to 0 immediately. No partial sync pulse is stretched.

Test Plan:
- Reset/release with CE_DIV=2 → ce_pix toggles 0,1,0,1; H reaches 1 on the first ce_pix; all outputs are 0 during reset.
- Run one full line → H wraps 923→0 and V 0→1 on the same ce_pix; hblank rises at H=704; hsync is high exactly for H=760..823 (64 pixels).
- Run one full frame → V wraps 261→0; sof pulses once at H=0,V=0; vbl_start pulses once at V=224,H=0; vsync is high for lines 234..236.
- Pulse cnt_rd at V=0,H=0 → vertcnt=8'h7D, horizcnt=8'h00.
- Pulse cnt_rd at V=261,H=14 → vertcnt=8'hFF, horizcnt=8'hC0.
- Assert reset_n low at V=100,H=500 for 3 cycles → H=V=0 and hsync=vblank=0 immediately; after release, the timing restarts cleanly from frame start.
